// File: rtl/ysyx_23060180_mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency memory port between the IFU and the LSU.
// Optional transaction/conflict counters are added when ARB_STAT_EN is defined.
module ysyx_23060180_mem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32
) (
    input  logic          clk,
    input  logic          rstn_in,
    input  logic          ifu_req,
    input  logic [AW-1:0] ifu_addr,
    output logic          ifu_done,
    output logic [31:0]   ifu_rdata,
    input  logic          lsu_req,
    input  logic          lsu_wr,
    input  logic [AW-1:0] lsu_addr,
    input  logic [31:0]   lsu_wdata,
    input  logic [3:0]    lsu_wmask,
    output logic          lsu_done,
    output logic [31:0]   lsu_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wmask,
    input  logic [31:0]   mem_rdata
`ifdef ARB_STAT_EN
   ,output logic [31:0]   stat_ifu_cnt,
    output logic [31:0]   stat_lsu_cnt,
    output logic [31:0]   stat_conflict_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_t     state;
    logic       owner_lsu;
    logic       last_lsu;
    logic       wr_q;
    logic [3:0] lat_cnt;
    logic       any_req;
    logic       pick_lsu;
    logic       pick_wr;

    // On a tie the requester that did not own the previous transaction wins.
    always_comb begin
        any_req  = ifu_req | lsu_req;
        pick_lsu = lsu_req & (~ifu_req | ~last_lsu);
        pick_wr  = pick_lsu & lsu_wr;
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            state     <= S_IDLE;
            owner_lsu <= 1'b0;
            last_lsu  <= 1'b1;
            wr_q      <= 1'b0;
            lat_cnt   <= '0;
            ifu_done  <= 1'b0;
            lsu_done  <= 1'b0;
            ifu_rdata <= '0;
            lsu_rdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
`ifdef ARB_STAT_EN
            stat_ifu_cnt      <= '0;
            stat_lsu_cnt      <= '0;
            stat_conflict_cnt <= '0;
`endif
        end else begin
            ifu_done <= 1'b0;
            lsu_done <= 1'b0;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        // Strobes are registered here so they are high exactly during ISSUE.
                        owner_lsu <= pick_lsu;
                        wr_q      <= pick_wr;
                        mem_rd    <= ~pick_wr;
                        mem_wr    <= pick_wr;
                        mem_addr  <= pick_lsu ? lsu_addr  : ifu_addr;
                        mem_wdata <= pick_lsu ? lsu_wdata : '0;
                        mem_wmask <= pick_lsu ? lsu_wmask : '0;
                        state     <= S_ISSUE;
`ifdef ARB_STAT_EN
                        if (ifu_req && lsu_req)
                            stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
`endif
                    end
                end
                S_ISSUE: begin
                    if (wr_q) begin
                        lsu_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        if (owner_lsu) begin
                            lsu_rdata <= mem_rdata;
                            lsu_done  <= 1'b1;
                        end else begin
                            ifu_rdata <= mem_rdata;
                            ifu_done  <= 1'b1;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    last_lsu <= owner_lsu;
                    state    <= S_IDLE;
`ifdef ARB_STAT_EN
                    if (owner_lsu)
                        stat_lsu_cnt <= stat_lsu_cnt + 32'd1;
                    else
                        stat_ifu_cnt <= stat_ifu_cnt + 32'd1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060180_mem_arbiter.sv
// Directed bench for ysyx_23060180_mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
// Counter checks are compiled in when ARB_STAT_EN is defined.
module tb_ysyx_23060180_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn_in;
    logic        ifu_req, lsu_req, lsu_wr, lsu3_req, ifu3_req;
    logic [31:0] ifu_addr, lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic [31:0] mem_rdata, mem3_rdata;

    logic        ifu_done, lsu_done, mem_rd, mem_wr;
    logic [31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        d3_ifu_done, d3_lsu_done, d3_mem_rd, d3_mem_wr;
    logic [31:0] d3_ifu_rdata, d3_lsu_rdata, d3_mem_addr, d3_mem_wdata;
    logic [3:0]  d3_mem_wmask;
`ifdef ARB_STAT_EN
    logic [31:0] stat_ifu_cnt, stat_lsu_cnt, stat_conflict_cnt;
    logic [31:0] d3_stat_ifu, d3_stat_lsu, d3_stat_conf;
`endif

    int npass = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    ysyx_23060180_mem_arbiter #(.MEM_LAT(1), .AW(32)) u_dut (
        .clk(clk), .rstn_in(rstn_in),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_done(ifu_done), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
`ifdef ARB_STAT_EN
       ,.stat_ifu_cnt(stat_ifu_cnt), .stat_lsu_cnt(stat_lsu_cnt),
        .stat_conflict_cnt(stat_conflict_cnt)
`endif
    );

    ysyx_23060180_mem_arbiter #(.MEM_LAT(3), .AW(32)) u_dut3 (
        .clk(clk), .rstn_in(rstn_in),
        .ifu_req(ifu3_req), .ifu_addr(ifu_addr), .ifu_done(d3_ifu_done), .ifu_rdata(d3_ifu_rdata),
        .lsu_req(lsu3_req), .lsu_wr(lsu_wr), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask), .lsu_done(d3_lsu_done), .lsu_rdata(d3_lsu_rdata),
        .mem_rd(d3_mem_rd), .mem_wr(d3_mem_wr), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
        .mem_wmask(d3_mem_wmask), .mem_rdata(mem3_rdata)
`ifdef ARB_STAT_EN
       ,.stat_ifu_cnt(d3_stat_ifu), .stat_lsu_cnt(d3_stat_lsu), .stat_conflict_cnt(d3_stat_conf)
`endif
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h8000_0000: mem_fn = 32'h0010_0093;
            32'h8000_0004: mem_fn = 32'h1234_5678;
            default:       mem_fn = a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    // Memory models: data only in the sample cycle, 0xFFFFFFFF otherwise.
    int          cnt1 = 0, cnt3 = 0;
    logic [31:0] a1 = '0, a3 = '0;
    always @(negedge clk) begin
        if (cnt1 > 0) begin cnt1--; mem_rdata = (cnt1 == 0) ? mem_fn(a1) : '1; end
        else mem_rdata = '1;
        if (mem_rd) begin cnt1 = 1; a1 = mem_addr; end
        if (cnt3 > 0) begin cnt3--; mem3_rdata = (cnt3 == 0) ? mem_fn(a3) : '1; end
        else mem3_rdata = '1;
        if (d3_mem_rd) begin cnt3 = 3; a3 = d3_mem_addr; end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_done(input bit want_lsu, input string tag);
        int n = 0;
        while (!(want_lsu ? lsu_done : ifu_done) && n < 20) begin
            step();
            n++;
        end
        check({tag, "_done"}, {31'd0, want_lsu ? lsu_done : ifu_done}, 32'd1);
        check({tag, "_other"}, {31'd0, want_lsu ? ifu_done : lsu_done}, 32'd0);
    endtask

    task automatic do_reset();
        rstn_in = 1'b0;
        step();
        @(negedge clk);
        rstn_in = 1'b1;
    endtask

    task automatic rd(input bit is_lsu, input logic [31:0] a, input string tag);
        if (is_lsu) begin lsu_req = 1'b1; lsu_wr = 1'b0; lsu_addr = a; end
        else begin ifu_req = 1'b1; ifu_addr = a; end
        step();
        wait_done(is_lsu, tag);
        check({tag, "_rdata"}, is_lsu ? lsu_rdata : ifu_rdata, mem_fn(a));
        if (is_lsu) lsu_req = 1'b0; else ifu_req = 1'b0;
        step();
    endtask

    task automatic tie_pair(input string tag);
        ifu_req = 1'b1; ifu_addr = 32'h8000_0300;
        lsu_req = 1'b1; lsu_wr = 1'b0; lsu_addr = 32'h8000_0400;
        step();
        wait_done(1'b0, {tag, "_ifu"});
        check({tag, "_ifu_rdata"}, ifu_rdata, mem_fn(32'h8000_0300));
        ifu_req = 1'b0;
        step();
        wait_done(1'b1, {tag, "_lsu"});
        check({tag, "_lsu_rdata"}, lsu_rdata, mem_fn(32'h8000_0400));
        lsu_req = 1'b0;
        step();
    endtask

    initial begin
        rstn_in = 1'b0;
        ifu_req = 1'b0; lsu_req = 1'b0; lsu_wr = 1'b0; lsu3_req = 1'b0; ifu3_req = 1'b0;
        ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_ifu_done", {31'd0, ifu_done}, 32'd0);
        check("rst_lsu_done", {31'd0, lsu_done}, 32'd0);
        check("rst_ifu_rdata", ifu_rdata, 32'd0);
        check("rst_lsu_rdata", lsu_rdata, 32'd0);
        @(negedge clk);
        rstn_in = 1'b1;
        step();

        // IFU-only read, MEM_LAT=1: done in the 4th cycle counting the request cycle.
        ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
        step();
        check("ifu_issue_rd", {31'd0, mem_rd}, 32'd1);
        check("ifu_issue_wr", {31'd0, mem_wr}, 32'd0);
        check("ifu_issue_addr", mem_addr, 32'h8000_0000);
        step();
        check("ifu_wait_rd", {31'd0, mem_rd}, 32'd0);
        check("ifu_wait_done", {31'd0, ifu_done}, 32'd0);
        step();
        check("ifu_done", {31'd0, ifu_done}, 32'd1);
        check("ifu_rdata", ifu_rdata, 32'h0010_0093);
        check("ifu_lsu_done", {31'd0, lsu_done}, 32'd0);
        ifu_req = 1'b0;
        step();
        check("ifu_done_pulse", {31'd0, ifu_done}, 32'd0);

        // LSU write: done in the 3rd cycle, lsu_rdata untouched.
        lsu_req = 1'b1; lsu_wr = 1'b1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        step();
        check("wr_issue_wr", {31'd0, mem_wr}, 32'd1);
        check("wr_issue_rd", {31'd0, mem_rd}, 32'd0);
        check("wr_issue_addr", mem_addr, 32'h8000_1000);
        check("wr_issue_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_issue_wmask", {28'd0, mem_wmask}, 32'hF);
        step();
        check("wr_done", {31'd0, lsu_done}, 32'd1);
        check("wr_strobe_off", {31'd0, mem_wr}, 32'd0);
        check("wr_rdata_kept", lsu_rdata, 32'd0);
        lsu_req = 1'b0; lsu_wr = 1'b0;
        step();
        check("wr_done_pulse", {31'd0, lsu_done}, 32'd0);
        check("wr_addr_hold", mem_addr, 32'h8000_1000);

        // MEM_LAT=3 LSU read: done in the 6th cycle despite glitching mem_rdata.
        lsu_addr = 32'h8000_0004; lsu3_req = 1'b1;
        step();
        check("l3_issue_rd", {31'd0, d3_mem_rd}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("l3_wait_done", {31'd0, d3_lsu_done}, 32'd0);
        end
        step();
        check("l3_done", {31'd0, d3_lsu_done}, 32'd1);
        check("l3_rdata", d3_lsu_rdata, 32'h1234_5678);
        lsu3_req = 1'b0;
        step();

        // Reset during WAIT of an IFU read, then a pending tie.
        ifu_req = 1'b1; ifu_addr = 32'h8000_0100;
        step();
        step();
        #1 rstn_in = 1'b0;
        #1;
        check("ar_mem_addr", mem_addr, 32'd0);
        check("ar_ifu_rdata", ifu_rdata, 32'd0);
        check("ar_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("ar_ifu_done", {31'd0, ifu_done}, 32'd0);
        lsu_req = 1'b1; lsu_wr = 1'b0; lsu_addr = 32'h8000_0200;
        step();
        check("ar_hold_done", {31'd0, ifu_done}, 32'd0);
        @(negedge clk);
        rstn_in = 1'b1;
        step();
        check("tie_first_rd", {31'd0, mem_rd}, 32'd1);
        check("tie_first_addr", mem_addr, 32'h8000_0100);
        for (int k = 0; k < 6; k++) begin
            int n = 0;
            while (!(ifu_done || lsu_done) && n < 20) begin
                step();
                n++;
            end
            check("tie_any_done", {31'd0, ifu_done | lsu_done}, 32'd1);
            check("tie_owner", {31'd0, lsu_done}, 32'(k % 2));
            check("tie_excl", {31'd0, ifu_done & lsu_done}, 32'd0);
            if (k % 2 == 0) check("tie_ifu_rdata", ifu_rdata, mem_fn(32'h8000_0100));
            else            check("tie_lsu_rdata", lsu_rdata, mem_fn(32'h8000_0200));
            if (k == 5) begin ifu_req = 1'b0; lsu_req = 1'b0; end
            step();
        end

        // 5 IFU and 3 LSU transactions, 2 of them grants on a tie.
        do_reset();
        tie_pair("tp0");
        tie_pair("tp1");
        rd(1'b0, 32'h8000_0500, "s_ifu0");
        rd(1'b0, 32'h8000_0504, "s_ifu1");
        rd(1'b1, 32'h8000_0600, "s_lsu0");
        rd(1'b0, 32'h8000_0508, "s_ifu2");
`ifdef ARB_STAT_EN
        check("stat_ifu", stat_ifu_cnt, 32'd5);
        check("stat_lsu", stat_lsu_cnt, 32'd3);
        check("stat_conflict", stat_conflict_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/ysyx_23060180_mem_arbiter.md
Name: ysyx_23060180_mem_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Serialises requests and allows one outstanding transaction at a time.
- Round-robin arbitration on simultaneous requests.
- Handles the memory's fixed read latency and returns read data and a one-cycle done pulse to the winning requester.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from the mem_rd cycle to the mem_rdata sample; legal range 1..15.
- AW, 32, address width.

Ports:
- clk  in  1  clock
- rstn_in  in  1  asynchronous, active-low reset
- ifu_req  in  1  IFU read request; held until ifu_done
- ifu_addr  in  AW  IFU address
- ifu_done  out  1  one-cycle completion pulse
- ifu_rdata  out  32  read data; valid when ifu_done=1
- lsu_req  in  1  LSU request; held until lsu_done
- lsu_wr  in  1  1=write, 0=read
- lsu_addr  in  AW  LSU address
- lsu_wdata  in  32  write data
- lsu_wmask  in  4  byte write mask
- lsu_done  out  1  one-cycle completion pulse
- lsu_rdata  out  32  read data; valid when lsu_done=1
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_wmask  out  4  memory write mask
- mem_rdata  in  32  memory read data

Behaviour:
- Reset (asynchronous, rstn_in=0):
  - state=IDLE; all outputs 0; rdata registers 0; last_owner=LSU, so IFU wins the first tie.
  - Reset mid-transaction abandons it; no done pulse is issued.
- States:
  - IDLE: arbitrates between requests.
  - ISSUE: drives the memory command.
  - WAIT: counts read latency.
  - DONE: pulses done to the owner.
- IDLE:
  - No req: stay.
  - One req: grant it.
  - Both reqs: grant the requester other than last_owner.
  - On grant: register owner, addr, wr, wdata and wmask (IFU: wr=0, wmask=0); go to ISSUE.
  - Requester inputs are ignored after grant.
- ISSUE (exactly one cycle):
  - mem_rd=!wr_q, mem_wr=wr_q.
  - mem_addr/mem_wdata/mem_wmask are driven from the registered values.
  - Read: counter=MEM_LAT-1, go to WAIT. Write: go to DONE.
- WAIT:
  - Counter>0: decrement.
  - Counter=0: capture mem_rdata into the owner's rdata register, go to DONE.
  - With MEM_LAT=1, mem_rdata is sampled the cycle after ISSUE.
- DONE (one cycle):
  - Owner's done=1 and its rdata is valid.
  - last_owner updated to owner; next state IDLE.
  - Write done leaves lsu_rdata unchanged.
- Requester protocol:
  - Requester must deassert req on the edge ending its done cycle, or present a new request.
  - A req high in IDLE is always treated as a new request.
- mem_rd/mem_wr are 0 outside ISSUE; mem_addr etc. hold their last value outside ISSUE.
- Latency:
  - Read: req to done = 3+MEM_LAT cycles (4 for MEM_LAT=1).
  - Write: req to done = 3 cycles.
- Never grants both requesters; never has two memory strobes active in the same cycle.
- Back-to-back, both requesting continuously: grants alternate IFU, LSU, IFU, ...

Optional Feature:
- Macro ARB_STAT_EN.
- When defined, adds output ports:
  - stat_ifu_cnt[31:0], stat_lsu_cnt[31:0]: increment on each done pulse of that requester.
  - stat_conflict_cnt[31:0]: increments on each IDLE cycle where both reqs are high and a grant is made.
- All counters reset to 0 and wrap from 0xFFFFFFFF to 0.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- IFU-only read, MEM_LAT=1, ifu_addr=0x80000000, memory returns 0x00100093:
  - mem_rd=1 with mem_addr=0x80000000 for exactly one cycle.
  - ifu_done 4 cycles after req with ifu_rdata=0x00100093; lsu_done stays 0.
- LSU write, addr=0x80001000, wdata=0xDEADBEEF, wmask=0xF:
  - Single mem_wr pulse with those values; mem_rd stays 0; lsu_done on cycle 3.
- Simultaneous IFU read and LSU read first after reset:
  - IFU granted first; LSU completes next; then with both still requesting, order continues IFU, LSU alternating over 6 transactions.
- MEM_LAT=3, LSU read of 0x80000004 returning 0x12345678:
  - lsu_done 6 cycles after req with lsu_rdata=0x12345678; mem_rdata glitched to 0xFFFFFFFF on non-sample cycles is ignored.
- rstn_in pulsed low during WAIT of an IFU read:
  - All outputs 0 immediately; no ifu_done; after release, a pending LSU+IFU tie grants IFU first.
- ARB_STAT_EN defined, 5 IFU and 3 LSU transactions with 2 ties:
  - stat_ifu_cnt=5, stat_lsu_cnt=3, stat_conflict_cnt=2.
